// File: rtl/idt6168_access_ctl.sv
// Access sequencer and two-port round-robin arbiter for a 4Kx4 IDT6168A-20 SRAM.
// Port 0 is the CPU side, port 1 the DMA/maintenance side. Each granted request becomes
// ACCESS_CYCLES cycles of CE_n low followed by one RECOVER cycle carrying the ACK.
// Optional feature: define IDT6168_CLEAR_EN to zero the whole SRAM after every reset.
module idt6168_access_ctl #(
  parameter int unsigned ACCESS_CYCLES = 2  // legal range 1..15
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [11:0] ADDR0_11_0,
  input  logic [11:0] ADDR1_11_0,
  input  logic [3:0]  WDATA0_3_0,
  input  logic [3:0]  WDATA1_3_0,
  output logic        ACK0,
  output logic        ACK1,
  output logic [3:0]  RDATA0_3_0,
  output logic [3:0]  RDATA1_3_0,
  output logic [11:0] A_11_0,
  output logic        CE_n,
  output logic        WE_n,
  output logic [3:0]  D_OUT_3_0,
  output logic        D_OE,
  input  logic [3:0]  D_IN_3_0,
  output logic        BUSY,
  output logic        CLEAR_DONE
);

  typedef enum logic [1:0] {StIdle, StAccess, StRecover, StClear} state_e;

  localparam logic [3:0] LP_LAST = 4'(ACCESS_CYCLES - 1);

  state_e      r_state;
  logic [3:0]  r_cyc;
  logic        r_port;
  logic        r_we;
  logic        r_last_grant;
  logic [11:0] r_addr;
  logic [3:0]  r_wdata;
  logic        r_ce_n;
  logic        r_we_n;
  logic        r_oe;
  logic        r_ack0;
  logic        r_ack1;
  logic [3:0]  r_rdata0;
  logic [3:0]  r_rdata1;
`ifdef IDT6168_CLEAR_EN
  logic        r_clear_mode;
  logic        r_clear_done;
`endif

  logic        w_gnt_valid;
  logic        w_gnt_port;
  logic        w_gnt_we;
  logic [11:0] w_gnt_addr;
  logic [3:0]  w_gnt_wdata;

  // Round-robin pick: a tie goes to the port that was not served last.
  always_comb begin
    w_gnt_valid = REQ0 | REQ1;
    w_gnt_port  = (REQ0 && REQ1) ? ~r_last_grant : REQ1;
    w_gnt_we    = w_gnt_port ? WE1 : WE0;
    w_gnt_addr  = w_gnt_port ? ADDR1_11_0 : ADDR0_11_0;
    w_gnt_wdata = w_gnt_port ? WDATA1_3_0 : WDATA0_3_0;
  end

  // Sequencer FSM; all SRAM strobes and handshakes are registered here.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
`ifdef IDT6168_CLEAR_EN
      r_state      <= StClear;
      r_clear_mode <= 1'b1;
      r_clear_done <= 1'b0;
`else
      r_state      <= StIdle;
`endif
      r_cyc        <= 4'd0;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= 12'h000;
      r_wdata      <= 4'h0;
      r_ce_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe         <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= 4'h0;
      r_rdata1     <= 4'h0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_gnt_valid) begin
            r_port  <= w_gnt_port;
            r_we    <= w_gnt_we;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_wdata;
            r_cyc   <= 4'd0;
            r_ce_n  <= 1'b0;
            r_we_n  <= ~w_gnt_we;
            r_oe    <= w_gnt_we;
            r_state <= StAccess;
          end
        end
        StAccess: begin
          if (r_cyc == LP_LAST) begin
            // Read data is captured on the edge that closes the strobe.
            if (!r_we) begin
              if (r_port) r_rdata1 <= D_IN_3_0;
              else        r_rdata0 <= D_IN_3_0;
            end
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
`ifdef IDT6168_CLEAR_EN
            if (!r_clear_mode) begin
              r_ack0 <= ~r_port;
              r_ack1 <= r_port;
            end
`else
            r_ack0  <= ~r_port;
            r_ack1  <= r_port;
`endif
            r_state <= StRecover;
          end else begin
            r_cyc <= r_cyc + 4'd1;
          end
        end
        StRecover: begin
`ifdef IDT6168_CLEAR_EN
          if (r_clear_mode) begin
            if (r_addr == 12'hFFF) begin
              r_clear_mode <= 1'b0;
              r_clear_done <= 1'b1;
              r_oe         <= 1'b0;
              r_state      <= StIdle;
            end else begin
              // Chain straight into the next clear write; no idle gap.
              r_addr  <= r_addr + 12'd1;
              r_cyc   <= 4'd0;
              r_ce_n  <= 1'b0;
              r_we_n  <= 1'b0;
              r_state <= StAccess;
            end
          end else begin
            r_last_grant <= r_port;
            r_oe         <= 1'b0;
            r_state      <= StIdle;
          end
`else
          r_last_grant <= r_port;
          r_oe         <= 1'b0;
          r_state      <= StIdle;
`endif
        end
`ifdef IDT6168_CLEAR_EN
        StClear: begin
          r_addr  <= 12'h000;
          r_wdata <= 4'h0;
          r_we    <= 1'b1;
          r_port  <= 1'b0;
          r_cyc   <= 4'd0;
          r_ce_n  <= 1'b0;
          r_we_n  <= 1'b0;
          r_oe    <= 1'b1;
          r_state <= StAccess;
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ACK0       = r_ack0;
  assign ACK1       = r_ack1;
  assign RDATA0_3_0 = r_rdata0;
  assign RDATA1_3_0 = r_rdata1;
  assign A_11_0     = r_addr;
  assign CE_n       = r_ce_n;
  assign WE_n       = r_we_n;
  assign D_OUT_3_0  = r_wdata;
  assign D_OE       = r_oe;
  assign BUSY       = (r_state != StIdle);
`ifdef IDT6168_CLEAR_EN
  assign CLEAR_DONE = r_clear_done;
`else
  assign CLEAR_DONE = 1'b1;
`endif

endmodule
